dram_axi_arbiter: RTL and testbench
===================================

Name: dram_axi_arbiter

Overview:
- Shares the single AXI-lite style DRAM port (AR/R, AW/W/B channels) between two requesters, e.g. the DRAM↔SD bridge and a host/debug master.
- Accepts single-beat read or write commands from each requester and arbitrates round-robin.
- Sequences the AXI channel handshakes and returns the response to the granted requester.
- Sits between the requesters and the DRAM slave; only one transaction is outstanding at a time.

Parameters:
ADDR_W, 32, DRAM byte-address width (AR_ADDR/AW_ADDR)
DATA_W, 64, data beat width (R_DATA/W_DATA)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset: synchronous, active-high (asserted = 1 despite the name)
req_valid  in  2  per-requester command valid, bit k = requester k
req_write  in  2  bit k: 1 = write, 0 = read
req_addr  in  2*ADDR_W  requester k address at [k*ADDR_W +: ADDR_W]
req_wdata  in  2*DATA_W  requester k write data at [k*DATA_W +: DATA_W]
req_ready  out  2  one-cycle accept pulse, bit k
resp_valid  out  2  one-cycle response pulse, bit k
resp_rdata  out  DATA_W  read data, valid with resp_valid
resp_err  out  1  1 if R_RESP/B_RESP != 2'b00, valid with resp_valid
AR_VALID  out  1  read address valid
AR_ADDR  out  ADDR_W  read address
AR_READY  in  1  read address ready
R_VALID  in  1  read data valid
R_DATA  in  DATA_W  read data
R_RESP  in  2  read response
R_READY  out  1  read data ready
AW_VALID  out  1  write address valid
AW_ADDR  out  ADDR_W  write address
AW_READY  in  1  write address ready
W_VALID  out  1  write data valid
W_DATA  out  DATA_W  write data
W_READY  in  1  write data ready
B_VALID  in  1  write response valid
B_RESP  in  2  write response
B_READY  out  1  write response ready

Behaviour:
- Reset (rst_n=1 at a rising edge): state IDLE, priority pointer = 0, captured command cleared. All outputs are 0 from the next cycle, including AR_ADDR, AW_ADDR, W_DATA and resp_rdata. Reset mid-transaction abandons the transaction; no resp_valid is issued.
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, RESP.
- Arbitration in IDLE is combinational on req_valid.
  - One request pending: that requester is granted.
  - Both pending: the requester named by the priority pointer is granted.
- Grant in cycle t:
  - req_ready[k]=1 in cycle t only.
  - req_write/addr/wdata of k and grant id are captured at the edge ending cycle t.
  - Priority pointer becomes ~k.
  - Next state is RADDR for a read, WADDR for a write.
- req_ready is never high outside IDLE. Requests arriving while busy wait; the requester must hold req_valid and its command stable.
- RADDR: AR_VALID=1, AR_ADDR=captured address, both held stable until AR_READY=1 is sampled; then go to RDATA.
- RDATA: R_READY=1. On R_VALID=1, capture R_DATA and err=(R_RESP!=0), then go to RESP.
- WADDR: AW_VALID=1, AW_ADDR held until AW_READY; then go to WDATA. W_VALID is not asserted before the AW handshake completes.
- WDATA: W_VALID=1, W_DATA held until W_READY; then go to WRESP.
- WRESP: B_READY=1. On B_VALID=1, capture err=(B_RESP!=0), then go to RESP.
- RESP (1 cycle): resp_valid[id]=1, resp_rdata=captured data (0 for writes), resp_err; next state IDLE.
- Outside its own state, each AXI valid/ready output and its address/data bus is 0. resp_rdata and resp_err are 0 when resp_valid=0.
- Best-case latency, slave ready with data the next cycle:
  - Read: grant t, AR_VALID t+1, R handshake t+2, resp_valid t+3, next grant possible t+4.
  - Write: grant t, AW t+1, W t+2, B t+3, resp_valid t+4.
- Handshakes with READY already high complete in one cycle. Arbitrary slave stall cycles are allowed, with no timeout.
- Inputs R_VALID and B_VALID arriving outside RDATA/WRESP are ignored.
- Back-to-back traffic: when both requesters stay valid, grants alternate 0,1,0,1…

Test Plan:
- Reset check: apply rst_n=1 for 2 cycles mid-WDATA, then release -> next cycle every output = 0, state IDLE; the following req_valid=2'b01 gets req_ready[0] immediately.
- Single read: req 0 reads addr 0x0000_1000, slave with AR_READY and R_VALID after 0 stall returns R_DATA=64'h0123_4567_89AB_CDEF, R_RESP=0 -> AR_ADDR=0x1000; resp_valid=2'b01 three cycles after grant with that data and err=0.
- Write with stalls: req 1 writes 64'hDEAD_BEEF_CAFE_F00D to 0x1FF8; slave holds AW_READY low 3 cycles and W_READY low 2 cycles -> AW_ADDR and W_DATA stay stable, W_VALID rises only after the AW handshake; DRAM word updated; resp_valid=2'b10, resp_rdata=0.
- Contention: req_valid=2'b11 held for 4 transactions after reset -> grant order 0,1,0,1; req_ready is never 2'b11.
- Error response: read returns R_RESP=2'b10 -> resp_err=1 with resp_valid; the following transaction with RESP=0 gives resp_err=0.
- Randomized: 500 mixed read/write from both requesters against pseudo_DRAM with random stalls -> read data matches a scoreboard model, and exactly one response is returned per accepted request to the correct requester.

Source files
------------

// File: rtl/dram_axi_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI-lite style DRAM port.
// One single-beat read or write is in flight at a time; the response is returned
// to whichever requester was granted.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction; arbitrate req_valid, pulse req_ready on grant
// RADDR  | AR_VALID with captured address until AR_READY
// RDATA  | R_READY until R_VALID, capture data and error
// WADDR  | AW_VALID with captured address until AW_READY
// WDATA  | W_VALID with captured data until W_READY
// WRESP  | B_READY until B_VALID, capture error
// RESP   | one-cycle resp_valid to the granted requester
module dram_axi_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req_valid,
   input  logic [1:0]            req_write,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic [1:0]            req_ready,
   output logic [1:0]            resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err,
   output logic                  AR_VALID,
   output logic [ADDR_W-1:0]     AR_ADDR,
   input  logic                  AR_READY,
   input  logic                  R_VALID,
   input  logic [DATA_W-1:0]     R_DATA,
   input  logic [1:0]            R_RESP,
   output logic                  R_READY,
   output logic                  AW_VALID,
   output logic [ADDR_W-1:0]     AW_ADDR,
   input  logic                  AW_READY,
   output logic                  W_VALID,
   output logic [DATA_W-1:0]     W_DATA,
   input  logic                  W_READY,
   input  logic                  B_VALID,
   input  logic [1:0]            B_RESP,
   output logic                  B_READY
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RADDR = 3'd1,
      ST_RDATA = 3'd2,
      ST_WADDR = 3'd3,
      ST_WDATA = 3'd4,
      ST_WRESP = 3'd5,
      ST_RESP  = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic                prio_q, prio_d;
   logic                id_q, id_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                grant_vld;
   logic                grant_id;

   // Round-robin pick among pending requesters; suppressed while reset is held
   // so no accept pulse is seen for a command that will not be captured.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if ((state_q == ST_IDLE) && !rst_n) begin
         case (req_valid)
            2'b01: begin
               grant_vld = 1'b1;
               grant_id  = 1'b0;
            end
            2'b10: begin
               grant_vld = 1'b1;
               grant_id  = 1'b1;
            end
            2'b11: begin
               grant_vld = 1'b1;
               grant_id  = prio_q;
            end
            default: begin
               grant_vld = 1'b0;
               grant_id  = 1'b0;
            end
         endcase
      end
   end

   // Next-state and capture logic for the transaction sequencer.
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      id_d    = id_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_vld) begin
               id_d    = grant_id;
               prio_d  = ~grant_id;
               addr_d  = grant_id ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
               wdata_d = grant_id ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
               // writes return zero data, so clear any stale read beat here
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = req_write[grant_id] ? ST_WADDR : ST_RADDR;
            end
         end
         ST_RADDR: begin
            if (AR_READY) state_d = ST_RDATA;
         end
         ST_RDATA: begin
            if (R_VALID) begin
               rdata_d = R_DATA;
               err_d   = (R_RESP != 2'b00);
               state_d = ST_RESP;
            end
         end
         ST_WADDR: begin
            if (AW_READY) state_d = ST_WDATA;
         end
         ST_WDATA: begin
            if (W_READY) state_d = ST_WRESP;
         end
         ST_WRESP: begin
            if (B_VALID) begin
               err_d   = (B_RESP != 2'b00);
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and captured-command registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= ST_IDLE;
         prio_q  <= 1'b0;
         id_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Channel outputs decoded from state; buses are zero outside their own state.
   always_comb begin
      req_ready  = 2'b00;
      resp_valid = 2'b00;
      resp_rdata = '0;
      resp_err   = 1'b0;
      AR_VALID   = 1'b0;
      AR_ADDR    = '0;
      R_READY    = 1'b0;
      AW_VALID   = 1'b0;
      AW_ADDR    = '0;
      W_VALID    = 1'b0;
      W_DATA     = '0;
      B_READY    = 1'b0;
      if (grant_vld) req_ready[grant_id] = 1'b1;
      case (state_q)
         ST_RADDR: begin
            AR_VALID = 1'b1;
            AR_ADDR  = addr_q;
         end
         ST_RDATA: begin
            R_READY = 1'b1;
         end
         ST_WADDR: begin
            AW_VALID = 1'b1;
            AW_ADDR  = addr_q;
         end
         ST_WDATA: begin
            W_VALID = 1'b1;
            W_DATA  = wdata_q;
         end
         ST_WRESP: begin
            B_READY = 1'b1;
         end
         ST_RESP: begin
            resp_valid[id_q] = 1'b1;
            resp_rdata       = rdata_q;
            resp_err         = err_q;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_dram_axi_arbiter.sv
// Directed and randomized bench for dram_axi_arbiter with a behavioural DRAM slave.
module tb_dram_axi_arbiter;

   logic          clk;
   logic          rst_n;
   logic [1:0]    req_valid;
   logic [1:0]    req_write;
   logic [63:0]   req_addr;
   logic [127:0]  req_wdata;
   logic [1:0]    req_ready;
   logic [1:0]    resp_valid;
   logic [63:0]   resp_rdata;
   logic          resp_err;
   logic          AR_VALID;
   logic [31:0]   AR_ADDR;
   logic          AR_READY;
   logic          R_VALID;
   logic [63:0]   R_DATA;
   logic [1:0]    R_RESP;
   logic          R_READY;
   logic          AW_VALID;
   logic [31:0]   AW_ADDR;
   logic          AW_READY;
   logic          W_VALID;
   logic [63:0]   W_DATA;
   logic          W_READY;
   logic          B_VALID;
   logic [1:0]    B_RESP;
   logic          B_READY;

   int checks = 0;
   int errors = 0;

   // slave configuration, written by the test tasks only
   int            cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
   bit            cfg_rand = 0, cfg_spur = 0, cfg_fixed = 0;
   logic [63:0]   cfg_fixed_data = '0;
   logic [1:0]    cfg_r_resp = 2'b00, cfg_b_resp = 2'b00;

   // slave-owned memory and observations
   bit   [63:0]   dram_mem [128];
   int            stab_viol = 0;
   int            w_early = 0;
   logic [31:0]   last_ar_addr = '0, last_aw_addr = '0;
   logic [63:0]   last_w_data = '0;

   logic [201:0]  all_outs;
   assign all_outs = {req_ready, resp_valid, resp_rdata, resp_err, AR_VALID, AR_ADDR, R_READY,
                      AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY};

   dram_axi_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
      .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
      .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
      .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
      .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time expired, required completion");
      $fatal(1, "watchdog");
   end

   function automatic int stall_of(input int c);
      return cfg_rand ? int'($urandom_range(0, 3)) : c;
   endfunction

   // Slave: decides READY/VALID at each falling edge; everything it drives holds
   // through the next rising edge, so a handshake it sees here is the one the DUT takes.
   initial begin : slave
      int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
      bit ar_act, aw_act, w_act, r_pend, b_pend, aw_done;
      logic [31:0] r_addr, w_addr;
      bit p_ar_stall, p_aw_stall, p_w_stall, p_rst;
      logic [31:0] p_ar_addr, p_aw_addr;
      logic [63:0] p_w_data;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      ar_act = 0; aw_act = 0; w_act = 0; r_pend = 0; b_pend = 0; aw_done = 0;
      r_addr = '0; w_addr = '0;
      p_ar_stall = 0; p_aw_stall = 0; p_w_stall = 0; p_rst = 1;
      p_ar_addr = '0; p_aw_addr = '0; p_w_data = '0;
      AR_READY = 0; R_VALID = 0; R_DATA = '0; R_RESP = 2'b00;
      AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 2'b00;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            ar_act = 0; aw_act = 0; w_act = 0; r_pend = 0; b_pend = 0; aw_done = 0;
            p_ar_stall = 0; p_aw_stall = 0; p_w_stall = 0; p_rst = 1;
            AR_READY = 0; R_VALID = 0; R_DATA = '0; R_RESP = 2'b00;
            AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 2'b00;
         end else begin
            if (!p_rst) begin
               if (p_ar_stall && (!AR_VALID || AR_ADDR !== p_ar_addr)) stab_viol++;
               if (p_aw_stall && (!AW_VALID || AW_ADDR !== p_aw_addr)) stab_viol++;
               if (p_w_stall && (!W_VALID || W_DATA !== p_w_data)) stab_viol++;
            end
            if (W_VALID && !aw_done) w_early++;

            R_VALID = 0; R_DATA = '0; R_RESP = 2'b00;
            if (r_pend) begin
               if (r_cnt > 0) r_cnt--;
               else begin
                  R_VALID = 1;
                  R_DATA  = cfg_fixed ? cfg_fixed_data : dram_mem[r_addr[9:3]];
                  R_RESP  = cfg_r_resp;
               end
            end else if (cfg_spur && $urandom_range(0, 1) == 1) begin
               R_VALID = 1; R_DATA = {$urandom, $urandom}; R_RESP = 2'b11;
            end
            if (R_VALID && R_READY && r_pend) r_pend = 0;

            B_VALID = 0; B_RESP = 2'b00;
            if (b_pend) begin
               if (b_cnt > 0) b_cnt--;
               else begin
                  B_VALID = 1; B_RESP = cfg_b_resp;
               end
            end else if (cfg_spur && $urandom_range(0, 1) == 1) begin
               B_VALID = 1; B_RESP = 2'b11;
            end
            if (B_VALID && B_READY && b_pend) b_pend = 0;

            AR_READY = 0;
            if (AR_VALID) begin
               if (!ar_act) begin ar_act = 1; ar_cnt = stall_of(cfg_ar); end
               if (ar_cnt > 0) ar_cnt--; else AR_READY = 1;
            end else ar_act = 0;
            if (AR_VALID && AR_READY) begin
               ar_act = 0; r_pend = 1; r_cnt = stall_of(cfg_r);
               r_addr = AR_ADDR; last_ar_addr = AR_ADDR;
            end

            AW_READY = 0;
            if (AW_VALID) begin
               if (!aw_act) begin aw_act = 1; aw_cnt = stall_of(cfg_aw); end
               if (aw_cnt > 0) aw_cnt--; else AW_READY = 1;
            end else aw_act = 0;

            W_READY = 0;
            if (W_VALID) begin
               if (!w_act) begin w_act = 1; w_cnt = stall_of(cfg_w); end
               if (w_cnt > 0) w_cnt--; else W_READY = 1;
            end else w_act = 0;
            if (W_VALID && W_READY) begin
               w_act = 0; aw_done = 0;
               dram_mem[w_addr[9:3]] = W_DATA; last_w_data = W_DATA;
               b_pend = 1; b_cnt = stall_of(cfg_b);
            end
            if (AW_VALID && AW_READY) begin
               aw_act = 0; aw_done = 1;
               w_addr = AW_ADDR; last_aw_addr = AW_ADDR;
            end

            p_ar_stall = AR_VALID && !AR_READY; p_ar_addr = AR_ADDR;
            p_aw_stall = AW_VALID && !AW_READY; p_aw_addr = AW_ADDR;
            p_w_stall  = W_VALID && !W_READY;   p_w_data  = W_DATA;
            p_rst = 0;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input int n);
      cyc();
      rst_n = 1;
      req_valid = 2'b00;
      repeat (n) cyc();
      rst_n = 0;
   endtask

   // Issues one command from requester k and waits for its grant and response.
   task automatic do_txn(input int k, input logic wr, input logic [31:0] a, input logic [63:0] d,
                         output int gw, output int lat, output logic [1:0] rv,
                         output logic [63:0] rd, output logic er, output bit ok);
      bit g;
      g = 0; ok = 0; gw = 0; lat = 0; rv = 2'b00; rd = '0; er = 0;
      cyc();
      req_valid[k] = 1; req_write[k] = wr;
      req_addr[k*32 +: 32] = a; req_wdata[k*64 +: 64] = d;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!g) begin
            if (req_ready[k]) g = 1; else gw++;
         end else begin
            lat++;
            if (resp_valid != 2'b00) begin
               rv = resp_valid; rd = resp_rdata; er = resp_err; ok = 1;
               break;
            end
         end
         cyc();
         if (g) req_valid[k] = 0;
      end
      req_valid[k] = 0;
   endtask

   task automatic test_reset();
      apply_reset(3);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (all_outs !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %h required 0", all_outs);
         end
         cyc();
      end
   endtask

   task automatic test_single_read();
      int gw, lat; logic [1:0] rv; logic [63:0] rd; logic er; bit ok;
      cfg_fixed = 1; cfg_fixed_data = 64'h0123_4567_89AB_CDEF;
      do_txn(0, 1'b0, 32'h0000_1000, '0, gw, lat, rv, rd, er, ok);
      cfg_fixed = 0;
      checks++; if (!ok) begin errors++; $display("FAIL rd_done: got no response, required one"); end
      checks++; if (gw != 0) begin errors++; $display("FAIL rd_grant_wait: got %0d required 0", gw); end
      checks++; if (lat != 3) begin errors++; $display("FAIL rd_latency: got %0d required 3", lat); end
      checks++; if (rv !== 2'b01) begin errors++; $display("FAIL rd_resp_valid: got %b required 01", rv); end
      checks++; if (rd !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL rd_data: got %h required 0123456789abcdef", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b required 0", er); end
      checks++; if (last_ar_addr !== 32'h0000_1000) begin errors++; $display("FAIL rd_ar_addr: got %h required 00001000", last_ar_addr); end
   endtask

   task automatic test_write_stalls();
      int gw, lat; logic [1:0] rv; logic [63:0] rd; logic er; bit ok;
      cfg_aw = 3; cfg_w = 2; cfg_b = 0;
      do_txn(1, 1'b1, 32'h0000_1FF8, 64'hDEAD_BEEF_CAFE_F00D, gw, lat, rv, rd, er, ok);
      cfg_aw = 0; cfg_w = 0;
      checks++; if (!ok) begin errors++; $display("FAIL wr_done: got no response, required one"); end
      checks++; if (lat != 9) begin errors++; $display("FAIL wr_latency: got %0d required 9", lat); end
      checks++; if (rv !== 2'b10) begin errors++; $display("FAIL wr_resp_valid: got %b required 10", rv); end
      checks++; if (rd !== '0) begin errors++; $display("FAIL wr_rdata: got %h required 0", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b required 0", er); end
      checks++; if (last_aw_addr !== 32'h0000_1FF8) begin errors++; $display("FAIL wr_aw_addr: got %h required 00001ff8", last_aw_addr); end
      checks++; if (last_w_data !== 64'hDEAD_BEEF_CAFE_F00D) begin errors++; $display("FAIL wr_w_data: got %h required deadbeefcafef00d", last_w_data); end
      checks++; if (dram_mem[127] !== 64'hDEAD_BEEF_CAFE_F00D) begin errors++; $display("FAIL wr_mem: got %h required deadbeefcafef00d", dram_mem[127]); end
      checks++; if (stab_viol != 0) begin errors++; $display("FAIL wr_stable: got %0d violations required 0", stab_viol); end
      checks++; if (w_early != 0) begin errors++; $display("FAIL wr_w_before_aw: got %0d required 0", w_early); end
   endtask

   task automatic test_reset_mid_write();
      int gw, lat; logic [1:0] rv; logic [63:0] rd; logic er; bit ok;
      bit g, seen_w; int bad_resp;
      g = 0; seen_w = 0; bad_resp = 0;
      cfg_w = 20;
      cyc();
      req_valid[0] = 1; req_write[0] = 1;
      req_addr[31:0] = 32'h0000_1FF0; req_wdata[63:0] = 64'h5555_AAAA_5555_AAAA;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready[0]) g = 1;
         if (W_VALID) begin seen_w = 1; break; end
         cyc();
         if (g) req_valid[0] = 0;
      end
      checks++; if (!seen_w) begin errors++; $display("FAIL mid_reach_wdata: got no W_VALID, required WDATA"); end
      cyc();
      req_valid[0] = 0;
      rst_n = 1;
      @(negedge clk); if (resp_valid !== 2'b00) bad_resp++;
      cyc();
      @(negedge clk); if (resp_valid !== 2'b00) bad_resp++;
      cyc();
      rst_n = 0;
      cfg_w = 0;
      @(negedge clk);
      checks++; if (all_outs !== '0) begin errors++; $display("FAIL mid_reset_outs: got %h required 0", all_outs); end
      checks++; if (bad_resp != 0) begin errors++; $display("FAIL mid_reset_resp: got %0d responses required 0", bad_resp); end
      cfg_fixed = 1; cfg_fixed_data = 64'h0F0F_1234_5678_F0F0;
      do_txn(0, 1'b0, 32'h0000_1000, '0, gw, lat, rv, rd, er, ok);
      cfg_fixed = 0;
      checks++; if (gw != 0) begin errors++; $display("FAIL mid_next_grant: got wait %0d required 0", gw); end
      checks++; if (!ok || rv !== 2'b01) begin errors++; $display("FAIL mid_next_resp: got %b required 01", rv); end
      checks++; if (rd !== 64'h0F0F_1234_5678_F0F0) begin errors++; $display("FAIL mid_next_data: got %h required 0f0f12345678f0f0", rd); end
      checks++; if (dram_mem[126] !== '0) begin errors++; $display("FAIL mid_abandoned_write: got %h required 0", dram_mem[126]); end
   endtask

   task automatic test_contention();
      int order [4];
      int n, nresp, both;
      int exp_order [4];
      n = 0; nresp = 0; both = 0;
      exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
      for (int i = 0; i < 4; i++) order[i] = -1;
      apply_reset(2);
      cfg_fixed = 1; cfg_fixed_data = 64'h1111_2222_3333_4444;
      cyc();
      req_valid = 2'b11; req_write = 2'b00;
      req_addr = {32'h0000_1008, 32'h0000_1000};
      for (int i = 0; i < 200 && n < 4; i++) begin
         @(negedge clk);
         if (req_ready === 2'b11) both++;
         if (resp_valid != 2'b00) nresp++;
         if (req_ready[0]) begin order[n] = 0; n++; end
         else if (req_ready[1]) begin order[n] = 1; n++; end
         if (n < 4) cyc();
      end
      cyc();
      req_valid = 2'b00;
      for (int i = 0; i < 50 && nresp < 4; i++) begin
         @(negedge clk);
         if (resp_valid != 2'b00) nresp++;
         if (nresp < 4) cyc();
      end
      cfg_fixed = 0;
      checks++; if (n != 4) begin errors++; $display("FAIL cont_grants: got %0d required 4", n); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (order[i] != exp_order[i]) begin
            errors++; $display("FAIL cont_order[%0d]: got %0d required %0d", i, order[i], exp_order[i]);
         end
      end
      checks++; if (both != 0) begin errors++; $display("FAIL cont_ready_both: got %0d cycles required 0", both); end
      checks++; if (nresp != 4) begin errors++; $display("FAIL cont_resps: got %0d required 4", nresp); end
   endtask

   task automatic test_error_resp();
      int gw, lat; logic [1:0] rv; logic [63:0] rd; logic er; bit ok;
      cfg_fixed = 1; cfg_fixed_data = 64'hBAD0_BAD0_BAD0_BAD0;
      cfg_r_resp = 2'b10;
      do_txn(0, 1'b0, 32'h0000_1000, '0, gw, lat, rv, rd, er, ok);
      checks++; if (!ok || er !== 1'b1 || rv !== 2'b01) begin errors++; $display("FAIL err_read_slverr: got err=%b valid=%b required err=1 valid=01", er, rv); end
      cfg_r_resp = 2'b00;
      do_txn(1, 1'b0, 32'h0000_1000, '0, gw, lat, rv, rd, er, ok);
      checks++; if (!ok || er !== 1'b0 || rv !== 2'b10) begin errors++; $display("FAIL err_read_okay: got err=%b valid=%b required err=0 valid=10", er, rv); end
      cfg_fixed = 0;
      cfg_b_resp = 2'b01;
      do_txn(0, 1'b1, 32'h0000_1FF0, 64'h7777_8888_9999_AAAA, gw, lat, rv, rd, er, ok);
      checks++; if (!ok || er !== 1'b1 || rd !== '0) begin errors++; $display("FAIL err_write_exokay: got err=%b data=%h required err=1 data=0", er, rd); end
      cfg_b_resp = 2'b00;
      do_txn(1, 1'b1, 32'h0000_1FF0, 64'h1234_0000_0000_4321, gw, lat, rv, rd, er, ok);
      checks++; if (!ok || er !== 1'b0) begin errors++; $display("FAIL err_write_okay: got err=%b required 0", er); end
   endtask

   task automatic test_random();
      bit   [63:0] model_mem [16];
      logic [63:0] q0 [$];
      logic [63:0] q1 [$];
      bit          pend [2];
      logic        cmd_wr [2];
      logic [31:0] cmd_addr [2];
      logic [63:0] cmd_data [2];
      int          cmd_idx [2];
      int          gen, accepted, resp_cnt, idx;
      bit          done;
      logic [63:0] exp;
      bit          have;
      gen = 0; accepted = 0; resp_cnt = 0; done = 0; exp = '0; have = 0;
      for (int i = 0; i < 16; i++) model_mem[i] = dram_mem[i];
      for (int k = 0; k < 2; k++) begin
         pend[k] = 0; cmd_wr[k] = 0; cmd_addr[k] = '0; cmd_data[k] = '0; cmd_idx[k] = 0;
      end
      cfg_rand = 1; cfg_spur = 1;
      for (int c = 0; c < 20000; c++) begin
         cyc();
         for (int k = 0; k < 2; k++) begin
            if (!pend[k] && gen < 500 && $urandom_range(0, 3) != 0) begin
               pend[k] = 1; gen++;
               idx = int'($urandom_range(0, 15));
               cmd_idx[k] = idx;
               cmd_wr[k] = logic'($urandom_range(0, 1));
               cmd_addr[k] = 32'h0000_2000 + (32'(idx) << 3);
               cmd_data[k] = {$urandom, $urandom};
            end
            req_valid[k] = pend[k];
            req_write[k] = cmd_wr[k];
            req_addr[k*32 +: 32] = cmd_addr[k];
            req_wdata[k*64 +: 64] = cmd_data[k];
         end
         @(negedge clk);
         if (req_ready === 2'b11) begin
            checks++; errors++;
            $display("FAIL rnd_ready_both: got 11 required one-hot");
         end
         for (int k = 0; k < 2; k++) begin
            if (req_ready[k]) begin
               if (!pend[k]) begin
                  checks++; errors++;
                  $display("FAIL rnd_ready_idle[%0d]: got ready required none", k);
               end else begin
                  if (cmd_wr[k]) begin
                     model_mem[cmd_idx[k]] = cmd_data[k];
                     exp = '0;
                  end else exp = model_mem[cmd_idx[k]];
                  if (k == 0) q0.push_back(exp); else q1.push_back(exp);
                  pend[k] = 0; accepted++;
               end
            end
         end
         if (resp_valid != 2'b00) begin
            resp_cnt++;
            have = 0;
            if (resp_valid == 2'b01 && q0.size() > 0) begin exp = q0.pop_front(); have = 1; end
            if (resp_valid == 2'b10 && q1.size() > 0) begin exp = q1.pop_front(); have = 1; end
            checks++;
            if (!have) begin
               errors++;
               $display("FAIL rnd_resp_owner: got resp_valid=%b required one pending requester", resp_valid);
            end else if (resp_rdata !== exp || resp_err !== 1'b0) begin
               errors++;
               $display("FAIL rnd_resp_data: got %h err=%b required %h err=0", resp_rdata, resp_err, exp);
            end
         end
         if (gen == 500 && !pend[0] && !pend[1] && q0.size() == 0 && q1.size() == 0) begin
            done = 1;
            break;
         end
      end
      cyc();
      req_valid = 2'b00;
      cfg_rand = 0; cfg_spur = 0;
      checks++; if (!done) begin errors++; $display("FAIL rnd_complete: got %0d responses of %0d accepted, required all", resp_cnt, accepted); end
      checks++; if (accepted != 500) begin errors++; $display("FAIL rnd_accepted: got %0d required 500", accepted); end
      checks++; if (resp_cnt != accepted) begin errors++; $display("FAIL rnd_resp_count: got %0d required %0d", resp_cnt, accepted); end
      checks++; if (stab_viol != 0 || w_early != 0) begin errors++; $display("FAIL rnd_protocol: got %0d unstable, %0d early W required 0", stab_viol, w_early); end
   endtask

   initial begin
      rst_n = 1;
      req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
      test_reset();
      test_single_read();
      test_write_stalls();
      test_reset_mid_write();
      test_contention();
      test_error_resp();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
